// File: rtl/nmu_pkg.sv
// Shared types and constants for the NMU receive-side stream blocks.
package nmu_pkg;

  localparam int DROP_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } demux_state_e;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    if (v == {DROP_CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + DROP_CNT_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/axis_demux_out_reg.sv
// Single egress register stage: one shared data/keep/last word plus a one-hot
// valid vector selecting which output port currently owns the word.
module axis_demux_out_reg
  import nmu_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int NUM_PORTS      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        load_i,
  input  logic [AXIS_ID_WIDTH-1:0]    port_i,
  input  logic [AXIS_BUS_WIDTH-1:0]   data_i,
  input  logic [AXIS_BUS_WIDTH/8-1:0] keep_i,
  input  logic                        last_i,
  input  logic [NUM_PORTS-1:0]        m_tready_i,
  output logic [AXIS_BUS_WIDTH-1:0]   data_o,
  output logic [AXIS_BUS_WIDTH/8-1:0] keep_o,
  output logic                        last_o,
  output logic [NUM_PORTS-1:0]        valid_o,
  output logic                        space_o
);

  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  logic [NUM_PORTS-1:0]      valid_q, valid_d;
  logic [AXIS_BUS_WIDTH-1:0] data_q, data_d;
  logic [KEEP_W-1:0]         keep_q, keep_d;
  logic                      last_q, last_d;
  logic [NUM_PORTS-1:0]      onehot_s;
  logic                      consume_s;

  // Port decode, handshake detection and next-state of the holding register.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      onehot_s[i] = (port_i == AXIS_ID_WIDTH'(i));
    end
    consume_s = |(valid_q & m_tready_i);
    space_o   = ~(|valid_q) | consume_s;
    valid_d   = valid_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    // A load may coincide with the consume of the held beat: no bubble.
    if (load_i) begin
      valid_d = onehot_s;
      data_d  = data_i;
      keep_d  = keep_i;
      last_d  = last_i;
    end else if (consume_s) begin
      valid_d = {NUM_PORTS{1'b0}};
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= {NUM_PORTS{1'b0}};
      data_q  <= {AXIS_BUS_WIDTH{1'b0}};
      keep_q  <= {KEEP_W{1'b0}};
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/axis_tdest_demux.sv
// Routes AXI-Stream packets to one of NUM_PORTS outputs by the tdest of the
// first beat; packets addressed beyond the last port are swallowed and counted.
module axis_tdest_demux
  import nmu_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  parameter int NUM_PORTS      = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]             axis_rx_s_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]           axis_rx_s_tkeep,
  input  logic                                  axis_rx_s_tlast,
  input  logic                                  axis_rx_s_tvalid,
  input  logic [AXIS_ID_WIDTH-1:0]              axis_rx_s_tdest,
  output logic                                  axis_rx_s_tready,
  output logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]   axis_rx_m_tdata,
  output logic [NUM_PORTS*AXIS_BUS_WIDTH/8-1:0] axis_rx_m_tkeep,
  output logic [NUM_PORTS-1:0]                  axis_rx_m_tlast,
  output logic [NUM_PORTS-1:0]                  axis_rx_m_tvalid,
  input  logic [NUM_PORTS-1:0]                  axis_rx_m_tready,
  output logic [DROP_CNT_WIDTH-1:0]             drop_count
);

  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
  localparam logic [AXIS_ID_WIDTH:0] PORT_LIMIT = (AXIS_ID_WIDTH + 1)'(NUM_PORTS);

  demux_state_e               state_q;
  logic [AXIS_ID_WIDTH-1:0]   cur_dest_q;
  logic [DROP_CNT_WIDTH-1:0]  drop_count_q;

  logic                       space_s;
  logic                       tready_s;
  logic                       accept_s;
  logic                       dest_ok_s;
  logic                       load_s;
  logic [AXIS_ID_WIDTH-1:0]   load_port_s;
  logic [AXIS_BUS_WIDTH-1:0]  data_s;
  logic [KEEP_W-1:0]          keep_s;
  logic                       last_s;

  // Ingress ready and routing decision for the beat on the input this cycle.
  always_comb begin
    if (!aresetn) begin
      tready_s = 1'b0;
    end else if (state_q == DROP) begin
      tready_s = 1'b1;
    end else begin
      tready_s = space_s;
    end
    accept_s  = axis_rx_s_tvalid & tready_s;
    dest_ok_s = ({1'b0, axis_rx_s_tdest} < PORT_LIMIT);
    case (state_q)
      IDLE: begin
        load_s      = accept_s & dest_ok_s;
        load_port_s = axis_rx_s_tdest;
      end
      FORWARD: begin
        load_s      = accept_s;
        load_port_s = cur_dest_q;
      end
      DROP: begin
        load_s      = 1'b0;
        load_port_s = cur_dest_q;
      end
      default: begin
        load_s      = 1'b0;
        load_port_s = cur_dest_q;
      end
    endcase
  end

  // Packet FSM: destination latch on the first beat and drop accounting.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      cur_dest_q   <= {AXIS_ID_WIDTH{1'b0}};
      drop_count_q <= {DROP_CNT_WIDTH{1'b0}};
    end else if (accept_s) begin
      case (state_q)
        IDLE: begin
          cur_dest_q <= axis_rx_s_tdest;
          if (dest_ok_s) begin
            state_q <= axis_rx_s_tlast ? IDLE : FORWARD;
          end else begin
            drop_count_q <= sat_inc(drop_count_q);
            state_q      <= axis_rx_s_tlast ? IDLE : DROP;
          end
        end
        FORWARD: state_q <= axis_rx_s_tlast ? IDLE : FORWARD;
        DROP:    state_q <= axis_rx_s_tlast ? IDLE : DROP;
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_demux_out_reg #(
    .AXIS_BUS_WIDTH(AXIS_BUS_WIDTH),
    .AXIS_ID_WIDTH (AXIS_ID_WIDTH),
    .NUM_PORTS     (NUM_PORTS)
  ) u_out_reg (
    .clk_i     (aclk),
    .rst_n_i   (aresetn),
    .load_i    (load_s),
    .port_i    (load_port_s),
    .data_i    (axis_rx_s_tdata),
    .keep_i    (axis_rx_s_tkeep),
    .last_i    (axis_rx_s_tlast),
    .m_tready_i(axis_rx_m_tready),
    .data_o    (data_s),
    .keep_o    (keep_s),
    .last_o    (last_s),
    .valid_o   (axis_rx_m_tvalid),
    .space_o   (space_s)
  );

  assign axis_rx_s_tready = tready_s;
  assign axis_rx_m_tdata  = {NUM_PORTS{data_s}};
  assign axis_rx_m_tkeep  = {NUM_PORTS{keep_s}};
  assign axis_rx_m_tlast  = {NUM_PORTS{last_s}};
  assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_axis_tdest_demux.sv
// Directed bench for axis_tdest_demux: the driver pushes expected beats into a
// scoreboard queue, an independent negedge monitor pops and compares them.
module tb_axis_tdest_demux;

  localparam int W   = 64;
  localparam int IDW = 4;
  localparam int NP  = 4;
  localparam int KW  = W / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [W-1:0]      s_tdata;
  logic [KW-1:0]     s_tkeep;
  logic              s_tlast;
  logic              s_tvalid;
  logic [IDW-1:0]    s_tdest;
  logic              s_tready;
  logic [NP*W-1:0]   m_tdata;
  logic [NP*KW-1:0]  m_tkeep;
  logic [NP-1:0]     m_tlast;
  logic [NP-1:0]     m_tvalid;
  logic [NP-1:0]     m_tready;
  logic [31:0]       drop_count;

  typedef struct {
    int            port;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 aclk = ~aclk;

  axis_tdest_demux #(.AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW), .NUM_PORTS(NP)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .axis_rx_s_tdata (s_tdata),
    .axis_rx_s_tkeep (s_tkeep),
    .axis_rx_s_tlast (s_tlast),
    .axis_rx_s_tvalid(s_tvalid),
    .axis_rx_s_tdest (s_tdest),
    .axis_rx_s_tready(s_tready),
    .axis_rx_m_tdata (m_tdata),
    .axis_rx_m_tkeep (m_tkeep),
    .axis_rx_m_tlast (m_tlast),
    .axis_rx_m_tvalid(m_tvalid),
    .axis_rx_m_tready(m_tready),
    .drop_count      (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected beat per egress handshake, checks hold-while-stalled.
  logic          stall_prev = 1'b0;
  logic [NP-1:0] prev_valid;
  logic [W-1:0]  prev_data;
  logic [KW-1:0] prev_keep;
  int            prev_port;
  always @(negedge aclk) begin
    exp_t e;
    if (stall_prev) begin
      check("hold_valid", 64'(m_tvalid), 64'(prev_valid));
      check("hold_data", m_tdata[prev_port*W +: W], prev_data);
      check("hold_keep", 64'(m_tkeep[prev_port*KW +: KW]), 64'(prev_keep));
    end
    if (m_tvalid != '0) check("onehot", 64'($countones(m_tvalid)), 64'd1);
    for (int p = 0; p < NP; p++) begin
      if (m_tvalid[p] && m_tready[p]) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: port %0d data %0h, scoreboard empty", p, m_tdata[p*W +: W]);
        end else begin
          e = sb_q.pop_front();
          check("port", 64'(p), 64'(e.port));
          check("data", m_tdata[p*W +: W], e.data);
          check("keep", 64'(m_tkeep[p*KW +: KW]), 64'(e.keep));
          check("last", 64'(m_tlast[p]), 64'(e.last));
        end
      end
    end
    stall_prev = aresetn && ((m_tvalid & ~m_tready) != '0);
    prev_valid = m_tvalid;
    prev_port  = 0;
    for (int p = 0; p < NP; p++) if (m_tvalid[p]) prev_port = p;
    prev_data = m_tdata[prev_port*W +: W];
    prev_keep = m_tkeep[prev_port*KW +: KW];
  end

  // Drive one beat until accepted; exp_port < 0 means the beat must be dropped.
  task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l,
                      input logic [IDW-1:0] dest, input int exp_port, input bit chk_lat,
                      output int waits);
    exp_t e;
    bit   done;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tdest  = dest;
    s_tvalid = 1'b1;
    waits    = 0;
    done     = 1'b0;
    while (!done && waits < 100) begin
      @(negedge aclk);
      if (s_tready) begin
        if (exp_port >= 0) begin
          e.port = exp_port; e.data = d; e.keep = k; e.last = l;
          sb_q.push_back(e);
        end
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge aclk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, waits);
    end
    #1;
    if (chk_lat) begin
      if (exp_port >= 0) check("latency_valid", 64'(m_tvalid), 64'(1) << exp_port);
      else               check("drop_no_valid", 64'(m_tvalid), 64'd0);
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    s_tdest  = '0;
    m_tready = {NP{1'b1}};
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    @(negedge aclk);
    check("rst_tready", 64'(s_tready), 64'd0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("idle_tready", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;

    // 3-beat packet to port 2.
    send(64'h2222_0000_0000_0001, 8'hFF, 1'b0, 4'd2, 2, 1'b1, w);
    send(64'h2222_0000_0000_0002, 8'hFF, 1'b0, 4'd2, 2, 1'b1, w);
    send(64'h2222_0000_0000_0003, 8'h0F, 1'b1, 4'd2, 2, 1'b1, w);

    // Mid-packet tdest change is ignored.
    send(64'h1111_0000_0000_00A0, 8'hFF, 1'b0, 4'd1, 1, 1'b1, w);
    send(64'h1111_0000_0000_00A1, 8'hFF, 1'b0, 4'd3, 1, 1'b1, w);
    send(64'h1111_0000_0000_00A2, 8'h03, 1'b1, 4'd0, 1, 1'b1, w);

    // 4-beat packet to nonexistent port 5 is dropped without backpressure.
    for (int i = 0; i < 4; i++) begin
      send(64'hDEAD_0000_0000_0000 + 64'(i), 8'hFF, (i == 3), 4'd5, -1, 1'b1, w);
      check("drop_waits", 64'(w), 64'd0);
    end
    check("drop_count_1", 64'(drop_count), 64'd1);

    // Port-0 packet with a 5-cycle sink stall after beat 1.
    send(64'h0000_0000_0000_00B0, 8'hFF, 1'b0, 4'd0, 0, 1'b1, w);
    send(64'h0000_0000_0000_00B1, 8'hFF, 1'b0, 4'd0, 0, 1'b1, w);
    m_tready[0] = 1'b0;
    fork
      begin
        send(64'h0000_0000_0000_00B2, 8'hFF, 1'b0, 4'd0, 0, 1'b1, w);
        check("stall_waits", 64'(w), 64'd5);
      end
      begin
        repeat (5) @(posedge aclk);
        #1 m_tready[0] = 1'b1;
      end
    join
    send(64'h0000_0000_0000_00B3, 8'h01, 1'b1, 4'd0, 0, 1'b1, w);

    // Back-to-back single-beat packets, one per cycle to ports 0..3.
    for (int p = 0; p < NP; p++) begin
      send(64'hC0C0_0000_0000_0000 + 64'(p), 8'hFF, 1'b1, IDW'(p), p, 1'b1, w);
      check("b2b_waits", 64'(w), 64'd0);
    end

    // tdest == NUM_PORTS is the first out-of-range value: single-beat drop.
    send(64'h0000_0000_0000_0DD4, 8'hFF, 1'b1, 4'd4, -1, 1'b1, w);
    check("drop_count_2", 64'(drop_count), 64'd2);
    send(64'h3333_0000_0000_0001, 8'hFF, 1'b1, 4'd3, 3, 1'b1, w);

    // Reset on beat 2 of a 4-beat port-1 packet.
    send(64'h5555_0000_0000_0000, 8'hFF, 1'b0, 4'd1, 1, 1'b1, w);
    send(64'h5555_0000_0000_0001, 8'hFF, 1'b0, 4'd1, 1, 1'b1, w);
    s_tdata  = 64'h5555_0000_0000_0002;
    s_tdest  = 4'd1;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    aresetn  = 1'b0;
    @(negedge aclk);
    check("reset_tready", 64'(s_tready), 64'd0);
    @(posedge aclk);
    #1;
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_drop_count", 64'(drop_count), 64'd0);
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    send(64'h6666_0000_0000_0000, 8'hFF, 1'b1, 4'd0, 0, 1'b1, w);

    // Drop accounting restarts from zero after reset.
    send(64'h0000_0000_0000_0EEF, 8'hFF, 1'b1, 4'd15, -1, 1'b1, w);
    check("drop_count_after_rst", 64'(drop_count), 64'd1);

    repeat (5) @(posedge aclk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
